modinv249857s: RTL and testbench



---
 rtl/modq249857_pkg.sv | 38 +++
 rtl/modmul249857s.sv | 40 ++++
 rtl/modinv249857s.sv | 156 +++++++++++++++
 tb/tb_modinv249857s.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/modq249857_pkg.sv
// Shared constants, FSM encodings and the folding helper for arithmetic modulo Q = 249857.
// The CHK state only exists when MODINV249857_CHECK_EN is defined.
package modq249857_pkg;

    localparam int Q        = 249857;
    localparam int QH       = 124928;
    localparam logic [17:0] E = 18'h3CFFF;
    localparam int W_OP     = 18;
    localparam int W_PROD   = 35;
    localparam int LAT_BASE = 98;
    localparam int LAT_CHK  = 101;

    // 2^18 mod Q, so that hi*2^18 + lo == hi*FOLD_K + lo (mod Q)
    localparam logic signed [35:0] FOLD_K = 36'sd12287;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_WAIT = 3'd4,
`ifdef MODINV249857_CHECK_EN
        ST_CHK  = 3'd5,
`endif
        ST_DONE = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_SQR = 2'd0,
        OP_MUL = 2'd1,
        OP_CHK = 2'd2
    } op_t;

    function automatic logic signed [35:0] fold18(input logic signed [35:0] z);
        return (z >>> 18) * FOLD_K + $signed({18'd0, z[17:0]});
    endfunction

endpackage

// File: rtl/modmul249857s.sv
// Signed reducer: 35-bit product to [-QH, QH] mod Q; inZ sampled at edge 1, outZ valid after edge 2.
// No handshake: free-running pipeline, synchronous active-high reset.
module modmul249857s
    import modq249857_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [W_PROD-1:0]   inZ,
    output logic signed [W_OP-1:0]     outZ
);

    localparam logic signed [19:0] Q20  = 20'(Q);
    localparam logic signed [19:0] QH20 = 20'(QH);

    logic signed [35:0] f1_d;
    logic signed [26:0] z2_d, z2_q;
    logic signed [35:0] f3_d;
    logic signed [19:0] z4_d, z4_q;

    // Two folds per stage shrink |z| from <2^34 to <2^26, then to [-86009, 348152].
    always_comb begin
        f1_d = fold18(36'(inZ));
        z2_d = 27'(fold18(f1_d));
        f3_d = fold18(36'(z2_q));
        z4_d = 20'(fold18(f3_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z2_q <= '0;
            z4_q <= '0;
        end else begin
            z2_q <= z2_d;
            z4_q <= z4_d;
        end
    end

    assign outZ = 18'((z4_q > QH20) ? z4_q - Q20 : z4_q);

endmodule

// File: rtl/modinv249857s.sv
// Fermat inverter outC = inA^(Q-2) mod Q; done 98 cycles after start (101 with MODINV249857_CHECK_EN).
// start is ignored while busy and on the done cycle; one reducer shared by all 32 (+1) operations.
module modinv249857s
    import modq249857_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [W_OP-1:0]  inA,
    output logic                    busy,
    output logic                    done,
    output logic signed [W_OP-1:0]  outC,
    output logic                    err
);

`ifdef MODINV249857_CHECK_EN
    localparam state_t ST_FIN = ST_CHK;
`else
    localparam state_t ST_FIN = ST_DONE;
`endif

    state_t                 state_q;
    op_t                    op_q;
    logic signed [W_OP-1:0] acc_q;
    logic signed [W_OP-1:0] a_q;
    logic [4:0]             idx_q;
    logic                   wcnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic signed [W_OP-1:0] outC_q;
`ifdef MODINV249857_CHECK_EN
    logic                   err_q;
    logic                   chk_err_q;
`endif

    logic signed [W_OP-1:0]   opnd;
    logic signed [W_PROD-1:0] prod;
    logic signed [W_OP-1:0]   red;

    // Only the issue cycle's product matters; the reducer registers it on the next edge.
    assign opnd = (state_q == ST_SQR) ? acc_q : a_q;
    assign prod = 35'(acc_q) * 35'(opnd);

    modmul249857s u_red (
        .clk  (clk),
        .rst  (~rst_n),
        .inZ  (prod),
        .outZ (red)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_SQR;
            acc_q     <= '0;
            a_q       <= '0;
            idx_q     <= 5'd16;
            wcnt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            outC_q    <= '0;
`ifdef MODINV249857_CHECK_EN
            err_q     <= 1'b0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        a_q     <= inA;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    acc_q   <= a_q;
                    idx_q   <= 5'd16;
                    state_q <= ST_SQR;
                end
                ST_SQR: begin
                    op_q    <= OP_SQR;
                    wcnt_q  <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_MUL: begin
                    op_q    <= OP_MUL;
                    wcnt_q  <= 1'b0;
                    state_q <= ST_WAIT;
                end
`ifdef MODINV249857_CHECK_EN
                ST_CHK: begin
                    op_q    <= OP_CHK;
                    wcnt_q  <= 1'b0;
                    state_q <= ST_WAIT;
                end
`endif
                ST_WAIT: begin
                    if (!wcnt_q) begin
                        wcnt_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_SQR: begin
                                acc_q <= red;
                                if (E[idx_q]) begin
                                    state_q <= ST_MUL;
                                end else if (idx_q == 5'd0) begin
                                    state_q <= ST_FIN;
                                end else begin
                                    idx_q   <= idx_q - 5'd1;
                                    state_q <= ST_SQR;
                                end
                            end
                            OP_MUL: begin
                                acc_q <= red;
                                if (idx_q == 5'd0) begin
                                    state_q <= ST_FIN;
                                end else begin
                                    idx_q   <= idx_q - 5'd1;
                                    state_q <= ST_SQR;
                                end
                            end
`ifdef MODINV249857_CHECK_EN
                            OP_CHK: begin
                                chk_err_q <= (red != 18'sd1) && (a_q != '0);
                                state_q   <= ST_DONE;
                            end
`endif
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_DONE: begin
                    outC_q  <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
`ifdef MODINV249857_CHECK_EN
                    err_q   <= chk_err_q;
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign outC = outC_q;
`ifdef MODINV249857_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_modinv249857s.sv
// Scoreboard bench for modinv249857s: fixed values, zero, ignored starts, mid-run reset, random sweep.
module tb_modinv249857s;
    import modq249857_pkg::*;

`ifdef MODINV249857_CHECK_EN
    localparam int LAT = LAT_CHK;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic signed [17:0] inA = '0;
    logic              busy;
    logic              done;
    logic signed [17:0] outC;
    logic              err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int a;
        int c;
        bit e;
    } exp_t;
    exp_t sb[$];

    modinv249857s dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .inA   (inA),
        .busy  (busy),
        .done  (done),
        .outC  (outC),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic int ref_inv(input int a);
        longint b;
        longint r;
        b = ((longint'(a) % Q) + Q) % Q;
        r = 1;
        for (int i = 17; i >= 0; i--) begin
            r = (r * r) % Q;
            if (E[i]) r = (r * b) % Q;
        end
        if (r > QH) r = r - Q;
        return int'(r);
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
    task automatic issue(input int a, input int c, input bit e);
        exp_t x;
        x.a = a; x.c = c; x.e = e;
        sb.push_back(x);
        start = 1'b1;
        inA   = 18'(a);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        int n;
        cyc = -1;
        n = 0;
        while (n < 400 && cyc < 0) begin
            @(posedge clk); #1;
            n++;
            if (done) cyc = n;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (outC !== 18'sd0) begin bad++; $display("FAIL reset_outC got=%0d want=0", outC); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_values;
        int vals[6] = '{1, 2, 3, -1, 124928, 0};
        int outs[6] = '{1, -124928, 83286, -1, -2, 0};
        int cyc;
        exp_t x;
        for (int k = 0; k < 6; k++) begin
            issue(vals[k], outs[k], 1'b0);
            wait_done(cyc);
            x = sb.pop_front();
            total++; if (cyc != LAT) begin bad++; $display("FAIL val_latency a=%0d got=%0d want=%0d", x.a, cyc, LAT); end
            total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL val_outC a=%0d got=%0d want=%0d", x.a, outC, x.c); end
            total++; if (err !== x.e) begin bad++; $display("FAIL val_err a=%0d got=%b want=%b", x.a, err, x.e); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL val_busy_at_done a=%0d got=%b want=0", x.a, busy); end
            @(posedge clk); #1;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL val_done_pulse a=%0d got=%b want=0", x.a, done); end
            total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL val_outC_hold a=%0d got=%0d want=%0d", x.a, outC, x.c); end
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        exp_t x;
        repeat (4) @(posedge clk);
        #1;
        issue(2, -124928, 1'b0);
        for (int i = 1; i < 35; i++) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_midrun got=%b want=1", busy); end
        start = 1'b1; inA = 18'sd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        x = sb.pop_front();
        total++; if (cyc + 35 != LAT) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", cyc + 35, LAT); end
        total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL busy_outC got=%0d want=%0d", outC, x.c); end
        // start presented on the done cycle must be dropped
        start = 1'b1; inA = 18'sd3;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_cycle_start busy got=%b want=0", busy); end
        total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL done_cycle_outC got=%0d want=%0d", outC, x.c); end
        issue(3, 83286, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL accept_busy got=%b want=1", busy); end
        wait_done(cyc);
        x = sb.pop_front();
        total++; if (cyc != LAT) begin bad++; $display("FAIL next_latency got=%0d want=%0d", cyc, LAT); end
        total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL next_outC got=%0d want=%0d", outC, x.c); end
    endtask

    task automatic test_midrun_reset;
        int cyc;
        exp_t x;
        @(posedge clk); #1;
        issue(3, 83286, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (outC !== 18'sd0) begin bad++; $display("FAIL rst_outC got=%0d want=0", outC); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3, 83286, 1'b0);
        wait_done(cyc);
        x = sb.pop_front();
        total++; if (cyc != LAT) begin bad++; $display("FAIL post_rst_latency got=%0d want=%0d", cyc, LAT); end
        total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL post_rst_outC got=%0d want=%0d", outC, x.c); end
    endtask

    task automatic test_random;
        int cyc;
        int a;
        longint p;
        exp_t x;
        for (int k = 0; k < 150; k++) begin
            a = int'($urandom_range(249856, 0)) - 124928;
            @(posedge clk); #1;
            issue(a, ref_inv(a), 1'b0);
            wait_done(cyc);
            x = sb.pop_front();
            total++; if (cyc != LAT) begin bad++; $display("FAIL rnd_latency a=%0d got=%0d want=%0d", x.a, cyc, LAT); end
            total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL rnd_outC a=%0d got=%0d want=%0d", x.a, outC, x.c); end
            total++; if (err !== x.e) begin bad++; $display("FAIL rnd_err a=%0d got=%b want=%b", x.a, err, x.e); end
            if (x.a != 0) begin
                p = ((longint'(x.a) * longint'(outC)) % Q + Q) % Q;
                total++; if (p != 1) begin bad++; $display("FAIL rnd_product a=%0d outC=%0d residue=%0d want=1", x.a, outC, p); end
            end
        end
    endtask

`ifdef MODINV249857_CHECK_EN
    task automatic test_check_corrupt;
        int cyc;
        exp_t x;
        @(posedge clk); #1;
        issue(3, 83287, 1'b1);
        for (int i = 1; i <= 97; i++) begin @(posedge clk); #1; end
        force dut.acc_q = 18'sd83287;
        wait_done(cyc);
        release dut.acc_q;
        x = sb.pop_front();
        total++; if (cyc + 97 != LAT_CHK) begin bad++; $display("FAIL chk_latency got=%0d want=%0d", cyc + 97, LAT_CHK); end
        total++; if (err !== x.e) begin bad++; $display("FAIL chk_err got=%b want=%b", err, x.e); end
        total++; if (outC !== 18'(x.c)) begin bad++; $display("FAIL chk_outC got=%0d want=%0d", outC, x.c); end
    endtask
`endif

    initial begin
        test_reset();
        test_values();
        test_busy_ignore();
        test_midrun_reset();
        test_random();
`ifdef MODINV249857_CHECK_EN
        test_check_corrupt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
